// File: rtl/writeback_pipe.sv
// Y86-64 write-back stage: W pipeline register, 15-entry architectural register file with
// two combinational read ports, halt-status latch and retired-instruction counter.
module writeback_pipe #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              W_stall_i,
  input  logic              W_bubble_i,
  input  logic [2:0]        m_stat_i,
  input  logic [3:0]        M_icode_i,
  input  logic [3:0]        M_dstE_i,
  input  logic [3:0]        M_dstM_i,
  input  logic [DATA_W-1:0] M_valE_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [3:0]        rd_srcA_i,
  input  logic [3:0]        rd_srcB_i,
  output logic [DATA_W-1:0] rd_valA_o,
  output logic [DATA_W-1:0] rd_valB_o,
  output logic [2:0]        W_stat_o,
  output logic [3:0]        W_icode_o,
  output logic [3:0]        W_dstE_o,
  output logic [DATA_W-1:0] W_valE_o,
  output logic [3:0]        W_dstM_o,
  output logic [DATA_W-1:0] W_valM_o,
  output logic [2:0]        stat_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] INOP     = 4'h1;
  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [2:0]        w_stat;
  logic [3:0]        w_icode;
  logic [3:0]        w_dste;
  logic [3:0]        w_dstm;
  logic [DATA_W-1:0] w_vale;
  logic [DATA_W-1:0] w_valm;
  logic [2:0]        halt_stat;
  logic [CNT_W-1:0]  retired;
  logic [DATA_W-1:0] regs [NREG];

  logic running;
  logic w_ok;
  logic write_en;
  logic retire;

  assign running  = (state == RUN);
  assign w_ok     = (w_stat == STAT_AOK);
  assign write_en = running && w_ok;
  // A stalled W still holds the same instruction next cycle, so it retires only once.
  assign retire   = write_en && (w_icode != INOP) && !W_stall_i;

  // Next-state logic: a non-AOK status reaching write-back stops the machine for good.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (!w_ok) begin
          state_next = HALT;
        end else begin
          state_next = RUN;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // W pipeline register: stall beats bubble; frozen entirely once halted.
  always_ff @(posedge clk_i) begin
    if (rst_i || (running && !W_stall_i && W_bubble_i)) begin
      w_stat  <= STAT_AOK;
      w_icode <= INOP;
      w_dste  <= RNONE;
      w_dstm  <= RNONE;
      w_vale  <= {DATA_W{1'b0}};
      w_valm  <= {DATA_W{1'b0}};
    end else if (running && !W_stall_i) begin
      w_stat  <= m_stat_i;
      w_icode <= M_icode_i;
      w_dste  <= M_dstE_i;
      w_dstm  <= M_dstM_i;
      w_vale  <= M_valE_i;
      w_valm  <= m_valM_i;
    end
  end

  // Register file: the valM write is issued last so it wins when both ports name one register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (write_en) begin
      if (w_dste != RNONE) begin
        regs[w_dste] <= w_vale;
      end
      if (w_dstm != RNONE) begin
        regs[w_dstm] <= w_valm;
      end
    end
  end

  // Halt status latch and retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_stat <= STAT_AOK;
      retired   <= {CNT_W{1'b0}};
    end else begin
      if (running && !w_ok) begin
        halt_stat <= w_stat;
      end
      if (retire) begin
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // No write bypass: decode forwards from the W outputs itself.
  assign rd_valA_o = (rd_srcA_i == RNONE) ? {DATA_W{1'b0}} : regs[rd_srcA_i];
  assign rd_valB_o = (rd_srcB_i == RNONE) ? {DATA_W{1'b0}} : regs[rd_srcB_i];

  assign W_stat_o  = w_stat;
  assign W_icode_o = w_icode;
  assign W_dstE_o  = w_dste;
  assign W_valE_o  = w_vale;
  assign W_dstM_o  = w_dstm;
  assign W_valM_o  = w_valm;
  assign stat_o    = running ? w_stat : halt_stat;
  assign halted_o  = (state == HALT);
  assign retired_o = retired;

endmodule

// File: tb/tb_writeback_pipe.sv
// Testbench for writeback_pipe: directed scenarios plus randomized traffic, all checked
// against an abstract behavioural model of the write-back stage (4-bit retire counter build).
module tb_writeback_pipe;
  localparam int DATA_W = 64;
  localparam int NREG   = 15;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, w_stall, w_bubble;
  logic [2:0]        m_stat;
  logic [3:0]        m_icode, m_dste, m_dstm, rd_srca, rd_srcb;
  logic [DATA_W-1:0] m_vale, m_valm;
  logic [DATA_W-1:0] rd_vala, rd_valb, w_vale_o, w_valm_o;
  logic [2:0]        w_stat_o, stat;
  logic [3:0]        w_icode_o, w_dste_o, w_dstm_o;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  writeback_pipe #(.DATA_W(DATA_W), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .W_stall_i(w_stall), .W_bubble_i(w_bubble),
    .m_stat_i(m_stat), .M_icode_i(m_icode), .M_dstE_i(m_dste), .M_dstM_i(m_dstm),
    .M_valE_i(m_vale), .m_valM_i(m_valm), .rd_srcA_i(rd_srca), .rd_srcB_i(rd_srcb),
    .rd_valA_o(rd_vala), .rd_valB_o(rd_valb), .W_stat_o(w_stat_o), .W_icode_o(w_icode_o),
    .W_dstE_o(w_dste_o), .W_valE_o(w_vale_o), .W_dstM_o(w_dstm_o), .W_valM_o(w_valm_o),
    .stat_o(stat), .halted_o(halted), .retired_o(retired)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: architectural registers, the instruction sitting in W, halt flag, count.
  logic [DATA_W-1:0] mr [NREG];
  logic [2:0]        mw_stat, m_hstat;
  logic [3:0]        mw_icode, mw_dste, mw_dstm;
  logic [DATA_W-1:0] mw_vale, mw_valm;
  bit                m_halted;
  int unsigned       m_ret;

  task automatic model_bubble();
    mw_stat = 3'd1; mw_icode = 4'h1; mw_dste = 4'hF; mw_dstm = 4'hF;
    mw_vale = 64'd0; mw_valm = 64'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NREG; i++) mr[i] = 64'(i);
      model_bubble();
      m_halted = 1'b0; m_hstat = 3'd1; m_ret = 0;
    end else if (!m_halted) begin
      if (mw_stat != 3'd1) begin
        m_halted = 1'b1;
        m_hstat  = mw_stat;
      end else begin
        if (mw_dste != 4'hF) mr[mw_dste] = mw_vale;
        if (mw_dstm != 4'hF) mr[mw_dstm] = mw_valm;
        if (!w_stall && mw_icode != 4'h1) m_ret = (m_ret + 1) % (1 << CNT_W);
      end
      if (!w_stall) begin
        if (w_bubble) model_bubble();
        else begin
          mw_stat = m_stat; mw_icode = m_icode; mw_dste = m_dste; mw_dstm = m_dstm;
          mw_vale = m_vale; mw_valm = m_valm;
        end
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input logic [3:0] src);
    return (src == 4'hF) ? 64'd0 : mr[src];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    m_stat = st; m_icode = ic; m_dste = de; m_dstm = dm; m_vale = ve; m_valm = vm;
  endtask

  task automatic nop_in();
    w_stall = 1'b0; w_bubble = 1'b0;
    drive(3'd1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; nop_in(); step(); rst = 1'b0;
    rd_srca = 4'd3; rd_srcb = 4'hF; #1;
    compared++; if (rd_vala !== 64'd3) begin mismatched++; $display("FAIL reset_rdA: got %0h expected 3", rd_vala); end
    compared++; if (rd_valb !== 64'd0) begin mismatched++; $display("FAIL reset_rdB: got %0h expected 0", rd_valb); end
    compared++; if (stat !== 3'd1) begin mismatched++; $display("FAIL reset_stat: got %0d expected 1", stat); end
    compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    compared++; if (retired !== 4'd0) begin mismatched++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    compared++; if (w_dste_o !== 4'hF || w_icode_o !== 4'h1) begin mismatched++; $display("FAIL reset_W: got dstE %0h icode %0h expected F 1", w_dste_o, w_icode_o); end
  endtask

  task automatic test_opq();
    drive(3'd1, 4'h6, 4'd2, 4'hF, 64'h55, 64'd0); rd_srca = 4'd2; step(); #1;
    compared++; if (w_dste_o !== 4'd2 || w_vale_o !== 64'h55) begin mismatched++; $display("FAIL opq_W: got dstE %0h valE %0h expected 2 55", w_dste_o, w_vale_o); end
    compared++; if (rd_vala !== 64'd2) begin mismatched++; $display("FAIL opq_nobypass: got %0h expected 2", rd_vala); end
    nop_in(); step(); #1;
    compared++; if (rd_vala !== 64'h55) begin mismatched++; $display("FAIL opq_rd: got %0h expected 55", rd_vala); end
    compared++; if (retired !== 4'd1) begin mismatched++; $display("FAIL opq_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_popq();
    drive(3'd1, 4'hB, 4'd4, 4'd4, 64'h10, 64'h99); step(); nop_in(); step();
    rd_srca = 4'd4; #1;
    compared++; if (rd_vala !== 64'h99) begin mismatched++; $display("FAIL popq_same: got %0h expected 99", rd_vala); end
    drive(3'd1, 4'hB, 4'd4, 4'd0, 64'h10, 64'h77); step(); nop_in(); step();
    rd_srca = 4'd4; rd_srcb = 4'd0; #1;
    compared++; if (rd_vala !== 64'h10) begin mismatched++; $display("FAIL popq_rsp: got %0h expected 10", rd_vala); end
    compared++; if (rd_valb !== 64'h77) begin mismatched++; $display("FAIL popq_r0: got %0h expected 77", rd_valb); end
  endtask

  task automatic test_stall();
    int unsigned r0;
    drive(3'd1, 4'h6, 4'd1, 4'hF, 64'hAB, 64'd0); step();
    r0 = m_ret;
    w_stall = 1'b1; drive(3'd1, 4'h6, 4'd3, 4'hF, 64'hCC, 64'd0); rd_srca = 4'd1;
    repeat (3) begin
      step(); #1;
      compared++; if (w_dste_o !== 4'd1 || w_vale_o !== 64'hAB) begin mismatched++; $display("FAIL stall_hold: got dstE %0h valE %0h expected 1 ab", w_dste_o, w_vale_o); end
      compared++; if (rd_vala !== 64'hAB) begin mismatched++; $display("FAIL stall_rewrite: got %0h expected ab", rd_vala); end
      compared++; if (retired !== 4'(r0)) begin mismatched++; $display("FAIL stall_nocount: got %0d expected %0d", retired, r0); end
    end
    nop_in(); step(); #1;
    compared++; if (retired !== 4'((r0 + 1) % 16)) begin mismatched++; $display("FAIL stall_count: got %0d expected %0d", retired, (r0 + 1) % 16); end
    drive(3'd1, 4'h6, 4'd6, 4'hF, 64'h66, 64'd0); step();
    w_stall = 1'b1; w_bubble = 1'b1; step(); #1;
    compared++; if (w_dste_o !== 4'd6 || w_icode_o !== 4'h6) begin mismatched++; $display("FAIL stall_bubble: got dstE %0h icode %0h expected 6 6", w_dste_o, w_icode_o); end
    nop_in(); step();
  endtask

  task automatic test_halt();
    int unsigned r;
    drive(3'd2, 4'h0, 4'd5, 4'hF, 64'd7, 64'd0); step(); #1;
    compared++; if (stat !== 3'd2 || halted !== 1'b0) begin mismatched++; $display("FAIL halt_wstat: got stat %0d halted %0b expected 2 0", stat, halted); end
    drive(3'd1, 4'h6, 4'd5, 4'hF, 64'h1234, 64'd0); step(); #1;
    compared++; if (halted !== 1'b1 || stat !== 3'd2) begin mismatched++; $display("FAIL halt_enter: got halted %0b stat %0d expected 1 2", halted, stat); end
    r = m_ret;
    repeat (3) step();
    rd_srca = 4'd5; rd_srcb = 4'd2; #1;
    compared++; if (rd_vala !== 64'd5) begin mismatched++; $display("FAIL halt_nowrite: got %0h expected 5", rd_vala); end
    compared++; if (retired !== 4'(r) || halted !== 1'b1) begin mismatched++; $display("FAIL halt_frozen: got ret %0d halted %0b expected %0d 1", retired, halted, r); end
    rst = 1'b1; step(); rst = 1'b0; nop_in(); #1;
    compared++; if (halted !== 1'b0 || stat !== 3'd1 || retired !== 4'd0) begin mismatched++; $display("FAIL halt_reset: got halted %0b stat %0d ret %0d expected 0 1 0", halted, stat, retired); end
    compared++; if (rd_vala !== 64'd5 || rd_valb !== 64'd2) begin mismatched++; $display("FAIL halt_reset_rf: got %0h %0h expected 5 2", rd_vala, rd_valb); end
  endtask

  task automatic test_wrap();
    repeat (14) begin drive(3'd1, 4'h6, 4'hF, 4'hF, {$urandom(), $urandom()}, 64'd0); step(); end
    nop_in(); step(); #1;
    compared++; if (retired !== 4'd14) begin mismatched++; $display("FAIL wrap_pre: got %0d expected 14", retired); end
    repeat (2) begin drive(3'd1, 4'h6, 4'hF, 4'hF, 64'd1, 64'd0); step(); end
    nop_in(); step(); #1;
    compared++; if (retired !== 4'd0) begin mismatched++; $display("FAIL wrap: got %0d expected 0", retired); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst      = (m_halted && $urandom_range(0, 5) == 0) || ($urandom_range(0, 199) == 0);
      w_stall  = ($urandom_range(0, 3) == 0);
      w_bubble = ($urandom_range(0, 4) == 0);
      drive(($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
            4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom(), $urandom()}, {$urandom(), $urandom()});
      rd_srca = 4'($urandom_range(0, 15)); rd_srcb = 4'($urandom_range(0, 15)); #1;
      compared++; if (rd_vala !== exp_rd(rd_srca) || rd_valb !== exp_rd(rd_srcb)) begin mismatched++; $display("FAIL rnd_rd: cyc %0d got %0h %0h expected %0h %0h", n, rd_vala, rd_valb, exp_rd(rd_srca), exp_rd(rd_srcb)); end
      compared++; if ({w_stat_o, w_icode_o, w_dste_o, w_dstm_o, w_vale_o, w_valm_o} !== {mw_stat, mw_icode, mw_dste, mw_dstm, mw_vale, mw_valm}) begin mismatched++; $display("FAIL rnd_W: cyc %0d got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h", n, w_stat_o, w_icode_o, w_dste_o, w_dstm_o, mw_stat, mw_icode, mw_dste, mw_dstm); end
      compared++; if (stat !== (m_halted ? m_hstat : mw_stat) || halted !== m_halted) begin mismatched++; $display("FAIL rnd_stat: cyc %0d got %0d %0b expected %0d %0b", n, stat, halted, m_halted ? m_hstat : mw_stat, m_halted); end
      compared++; if (retired !== 4'(m_ret)) begin mismatched++; $display("FAIL rnd_retired: cyc %0d got %0d expected %0d", n, retired, m_ret); end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; nop_in(); rd_srca = 4'd0; rd_srcb = 4'd0;
    @(negedge clk);
    test_reset();
    test_opq();
    test_popq();
    test_stall();
    test_halt();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
